reg_read_stage: RTL

Register-read stage between the scheduler (issue) and execute_alu. It accepts one issued ALU micro-op per cycle, reads both source physical registers, and bypasses results from the execute forwarding bus. It then presents a registered exec packet to execute with a valid/ready handshake. A 2-entry output buffer (output register plus skid register) keeps the upstream ready signal registered. The whole stage is flushed on branch mispredict.

---
 rtl/reg_read_stage.sv | 212 +++++++++++++++++++++
 1 files changed

// File: rtl/reg_read_stage.sv
// Register-read stage: operand read/bypass, snooping two-entry output buffer, flushable.
// Optional perf counters are built only when RR_PERF_CNT_EN is defined.
module reg_read_stage #(
    parameter int PREG_W    = 6,
    parameter int ROB_IDX_W = 5,
    parameter int OPC_W     = 6
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 iss_valid,
    output logic                 iss_ready,
    input  logic [OPC_W-1:0]     iss_opcode,
    input  logic                 iss_alu_en,
    input  logic [PREG_W-1:0]    iss_src1_preg,
    input  logic [PREG_W-1:0]    iss_src2_preg,
    input  logic [PREG_W-1:0]    iss_dst_preg,
    input  logic [ROB_IDX_W-1:0] iss_rob_idx,
    input  logic                 iss_br_taken,
    output logic [PREG_W-1:0]    rf_rd_addr1,
    output logic [PREG_W-1:0]    rf_rd_addr2,
    input  logic [31:0]          rf_rd_data1,
    input  logic [31:0]          rf_rd_data2,
    input  logic                 fwd_valid,
    input  logic [PREG_W-1:0]    fwd_dst,
    input  logic [31:0]          fwd_val,
    input  logic                 flush,
    output logic                 ex_valid,
    input  logic                 ex_ready,
    output logic [OPC_W-1:0]     ex_opcode,
    output logic                 ex_alu_en,
    output logic [31:0]          ex_src1_val,
    output logic [31:0]          ex_src2_val,
    output logic [PREG_W-1:0]    ex_dst_preg,
    output logic [ROB_IDX_W-1:0] ex_rob_idx,
    output logic                 ex_br_taken,
    output logic [31:0]          perf_stall_cnt,
    output logic [31:0]          perf_byp_cnt
);

    typedef struct packed {
        logic [OPC_W-1:0]     opcode;
        logic                 alu_en;
        logic [PREG_W-1:0]    src1_preg;
        logic [PREG_W-1:0]    src2_preg;
        logic [31:0]          src1_val;
        logic [31:0]          src2_val;
        logic [PREG_W-1:0]    dst_preg;
        logic [ROB_IDX_W-1:0] rob_idx;
        logic                 br_taken;
    } pkt_t;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_FULL  = 2'd1,
        ST_SKID  = 2'd2
    } state_e;

    // Preg 0 is hard zero; otherwise a matching forward wins over the current value.
    function automatic logic [31:0] resolve_src(input logic [PREG_W-1:0] preg,
                                                input logic [31:0]       cur,
                                                input logic              fv,
                                                input logic [PREG_W-1:0] fd,
                                                input logic [31:0]       fval);
        logic [31:0] res;
        if (preg == {PREG_W{1'b0}}) begin
            res = 32'd0;
        end else if (fv && (fd == preg)) begin
            res = fval;
        end else begin
            res = cur;
        end
        return res;
    endfunction

    function automatic pkt_t snoop(input pkt_t p, input logic fv,
                                   input logic [PREG_W-1:0] fd, input logic [31:0] fval);
        pkt_t r;
        r          = p;
        r.src1_val = resolve_src(p.src1_preg, p.src1_val, fv, fd, fval);
        r.src2_val = resolve_src(p.src2_preg, p.src2_val, fv, fd, fval);
        return r;
    endfunction

    state_e state_q, state_d, state_nxt;
    pkt_t   out_q, out_d, skid_q, skid_d, new_pkt;
    logic   ex_valid_q, ex_valid_d, iss_ready_q, iss_ready_d;
    logic   accept_s, drain_s, capture_s;

    assign rf_rd_addr1 = iss_src1_preg;
    assign rf_rd_addr2 = iss_src2_preg;

    // Next-state, capture and snoop of the output/skid buffer.
    always_comb begin
        accept_s           = iss_valid & iss_ready_q;
        drain_s            = ex_valid_q & ex_ready;
        capture_s          = accept_s & ~flush;
        new_pkt.opcode     = iss_opcode;
        new_pkt.alu_en     = iss_alu_en;
        new_pkt.src1_preg  = iss_src1_preg;
        new_pkt.src2_preg  = iss_src2_preg;
        new_pkt.src1_val   = resolve_src(iss_src1_preg, rf_rd_data1, fwd_valid, fwd_dst, fwd_val);
        new_pkt.src2_val   = resolve_src(iss_src2_preg, rf_rd_data2, fwd_valid, fwd_dst, fwd_val);
        new_pkt.dst_preg   = iss_dst_preg;
        new_pkt.rob_idx    = iss_rob_idx;
        new_pkt.br_taken   = iss_br_taken;
        out_d              = snoop(out_q, fwd_valid, fwd_dst, fwd_val);
        skid_d             = snoop(skid_q, fwd_valid, fwd_dst, fwd_val);
        state_nxt          = state_q;
        case (state_q)
            ST_EMPTY: begin
                if (accept_s) begin
                    out_d     = new_pkt;
                    state_nxt = ST_FULL;
                end else begin
                    state_nxt = ST_EMPTY;
                end
            end
            ST_FULL: begin
                if (accept_s && drain_s) begin
                    out_d     = new_pkt;
                    state_nxt = ST_FULL;
                end else if (accept_s) begin
                    skid_d    = new_pkt;
                    state_nxt = ST_SKID;
                end else if (drain_s) begin
                    state_nxt = ST_EMPTY;
                end else begin
                    state_nxt = ST_FULL;
                end
            end
            ST_SKID: begin
                // skid_d already carries this cycle's snoop, so the moved op is current.
                if (drain_s) begin
                    out_d     = skid_d;
                    state_nxt = ST_FULL;
                end else begin
                    state_nxt = ST_SKID;
                end
            end
            default: begin
                state_nxt = ST_EMPTY;
            end
        endcase
        state_d     = flush ? ST_EMPTY : state_nxt;
        ex_valid_d  = (state_d != ST_EMPTY);
        iss_ready_d = (state_d != ST_SKID);
    end

    // Stage state, buffer entries and registered handshake outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_EMPTY;
            out_q       <= '0;
            skid_q      <= '0;
            ex_valid_q  <= 1'b0;
            iss_ready_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            out_q       <= out_d;
            skid_q      <= skid_d;
            ex_valid_q  <= ex_valid_d;
            iss_ready_q <= iss_ready_d;
        end
    end

    assign iss_ready   = iss_ready_q;
    assign ex_valid    = ex_valid_q;
    assign ex_opcode   = out_q.opcode;
    assign ex_alu_en   = out_q.alu_en;
    assign ex_src1_val = out_q.src1_val;
    assign ex_src2_val = out_q.src2_val;
    assign ex_dst_preg = out_q.dst_preg;
    assign ex_rob_idx  = out_q.rob_idx;
    assign ex_br_taken = out_q.br_taken;

`ifdef RR_PERF_CNT_EN
    function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [1:0] inc);
        logic [32:0] s;
        s = {1'b0, a} + {31'd0, inc};
        return s[32] ? 32'hFFFF_FFFF : s[31:0];
    endfunction

    logic        hit1_s, hit2_s;
    logic [31:0] stall_cnt_q, stall_cnt_d, byp_cnt_q, byp_cnt_d;

    // Saturating stall and capture-time bypass counters.
    always_comb begin
        hit1_s      = (iss_src1_preg != {PREG_W{1'b0}}) & fwd_valid & (fwd_dst == iss_src1_preg);
        hit2_s      = (iss_src2_preg != {PREG_W{1'b0}}) & fwd_valid & (fwd_dst == iss_src2_preg);
        stall_cnt_d = sat_add(stall_cnt_q, {1'b0, ex_valid_q & ~ex_ready});
        byp_cnt_d   = sat_add(byp_cnt_q, capture_s ? ({1'b0, hit1_s} + {1'b0, hit2_s}) : 2'd0);
    end

    // Counter registers, cleared only by reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_q <= 32'd0;
            byp_cnt_q   <= 32'd0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            byp_cnt_q   <= byp_cnt_d;
        end
    end

    assign perf_stall_cnt = stall_cnt_q;
    assign perf_byp_cnt   = byp_cnt_q;
`else
    assign perf_stall_cnt = 32'd0;
    assign perf_byp_cnt   = 32'd0;
`endif

endmodule
